atm_host_responder: RTL and testbench
=====================================

ATM_HOST_RESPONDER -- requirements
Module: atm_host_responder

Interface
REQ-001 Parameter NUM_ACC, default 10, number of account slots in the host database.
REQ-002 Parameter MAX_FAIL, default 3, consecutive bad-PIN logins before an account locks.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, idle cycles before an open session is dropped.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  terminal request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_op  input  3  0 LOGIN, 1 LOGOUT, 2 BALANCE, 3 WITHDRAW, 4 TRANSFER, 5-7 illegal.
REQ-009 req_acc  input  12  account number (LOGIN).
REQ-010 req_pin  input  4  PIN (LOGIN).
REQ-011 req_dest  input  12  destination account number (TRANSFER).
REQ-012 req_amount  input  11  amount (WITHDRAW, TRANSFER).
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  terminal accepts response.
REQ-015 rsp_status  output  3  0 OK, 1 BAD_CRED, 2 LOCKED, 3 NO_FUNDS, 4 NO_SESSION, 5 BAD_DEST, 6 OVERFLOW, 7 BAD_OP.
REQ-016 rsp_balance  output  16  session account balance after the operation; 0 when no session.
REQ-017 session_active  output  1  a logged-in session is open.

Function
REQ-018 FSM states IDLE, SEARCH, EXEC, RESPOND; req_ready SHALL be 1 only in IDLE.
REQ-019 Request accepted on req_valid&&req_ready; all req_* fields SHALL be captured in that cycle and ignored afterwards.
REQ-020 LOGIN and TRANSFER SHALL scan slots 0..NUM_ACC-1, one slot per cycle, always the full NUM_ACC cycles; other ops SHALL go IDLE->EXEC directly.
REQ-021 Latency: accept in cycle T; rsp_valid first high in T+NUM_ACC+2 for scan ops, T+2 otherwise.
REQ-022 rsp_valid, rsp_status, rsp_balance SHALL hold stable in RESPOND until rsp_valid&&rsp_ready, then return to IDLE the next cycle.
REQ-023 LOGIN: no account match -> BAD_CRED; match with fail count >= MAX_FAIL -> LOCKED; PIN mismatch -> BAD_CRED and fail count +1 (saturating); match -> OK, fail count cleared, session opened on that slot, replacing any prior session.
REQ-024 LOGOUT: always OK; session closed.
REQ-025 BALANCE, WITHDRAW, TRANSFER without session -> NO_SESSION, no state change.
REQ-026 WITHDRAW: amount <= balance -> subtract, OK; else NO_FUNDS, unchanged; amount 0 -> OK, unchanged.
REQ-027 TRANSFER precedence: dest not found -> BAD_DEST; amount > source balance -> NO_FUNDS; dest balance + amount > 65535 -> OVERFLOW; else OK with both balances updated in the same EXEC cycle; dest equal to source -> OK, balance unchanged.
REQ-028 Illegal op -> BAD_OP, no state change, no scan.
REQ-029 Idle counter SHALL count cycles in IDLE with an open session, clear on each accept, and at TIMEOUT_CYCLES close the session with no response generated.
REQ-030 Timeout expiring in the same cycle as an accept: the accept wins; counter clears, session kept.

Reset
REQ-031 On rst, at any point including mid-scan or mid-response: state IDLE, rsp_valid 0, rsp_status 0, rsp_balance 0, session closed, fail counts 0, idle counter 0, every balance 500; in-flight request discarded.
REQ-032 Account numbers SHALL be constants: 2749,2175,2429,2125,2178,2647,2816,2910,2299,2689 with PINs 0..9 respectively.

Structure
REQ-033 Shared package atm_pkg SHALL hold opcode and status encodings, FSM state encoding, the account/PIN table and the initial balance 500.
REQ-034 One sub-module acc_scanner SHALL hold the slot index counter and match flag/index for the SEARCH phase.

Verification
REQ-035 LOGIN 2175/PIN 1 -> OK, rsp_valid at T+12, rsp_balance 500, session_active 1.
REQ-036 Session on 2175: WITHDRAW 200 -> OK/300; WITHDRAW 301 -> NO_FUNDS/300.
REQ-037 TRANSFER 100 to 2689 -> OK/200, then login 2689/PIN 9 and BALANCE -> 600; TRANSFER to 1234 -> BAD_DEST.
REQ-038 Three LOGINs 2429/PIN 5 -> BAD_CRED x3; fourth with PIN 2 -> LOCKED; rst, then PIN 2 -> OK.
REQ-039 rsp_ready held low 20 cycles -> response held stable, req_ready 0; BALANCE with no session -> NO_SESSION; op 6 -> BAD_OP at T+2.
REQ-040 Login, then idle TIMEOUT_CYCLES -> session_active 0, BALANCE -> NO_SESSION; rst asserted mid-scan -> rsp_valid 0 immediately, no response.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared encodings for the ATM host responder: opcodes, statuses, FSM states,
// the captured-request record and the constant account/PIN table.
package atm_pkg;

   typedef enum logic [2:0] {
      OP_LOGIN    = 3'd0,
      OP_LOGOUT   = 3'd1,
      OP_BALANCE  = 3'd2,
      OP_WITHDRAW = 3'd3,
      OP_TRANSFER = 3'd4
   } op_e;

   typedef enum logic [2:0] {
      ST_OK         = 3'd0,
      ST_BAD_CRED   = 3'd1,
      ST_LOCKED     = 3'd2,
      ST_NO_FUNDS   = 3'd3,
      ST_NO_SESSION = 3'd4,
      ST_BAD_DEST   = 3'd5,
      ST_OVERFLOW   = 3'd6,
      ST_BAD_OP     = 3'd7
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SEARCH  = 2'd1,
      S_EXEC    = 2'd2,
      S_RESPOND = 2'd3
   } state_e;

   typedef struct packed {
      logic [2:0]  op;
      logic [11:0] acc;
      logic [3:0]  pin;
      logic [11:0] dest;
      logic [10:0] amount;
   } req_t;

   localparam int          ACC_TABLE_SIZE = 10;
   localparam logic [15:0] INIT_BALANCE   = 16'd500;

   // Slots beyond the table exist in the balance store but can never match.
   function automatic logic acc_known(input int unsigned idx);
      return idx < ACC_TABLE_SIZE;
   endfunction

   function automatic logic [11:0] acc_number(input int unsigned idx);
      case (idx)
         0:       return 12'd2749;
         1:       return 12'd2175;
         2:       return 12'd2429;
         3:       return 12'd2125;
         4:       return 12'd2178;
         5:       return 12'd2647;
         6:       return 12'd2816;
         7:       return 12'd2910;
         8:       return 12'd2299;
         9:       return 12'd2689;
         default: return 12'd0;
      endcase
   endfunction

   // PIN of slot i is simply i.
   function automatic logic [3:0] acc_pin(input int unsigned idx);
      return 4'(idx);
   endfunction

endpackage

// File: rtl/acc_scanner.sv
// Sequential account search: walks one slot per step and remembers the first
// slot whose account number equals the key.
module acc_scanner
   import atm_pkg::*;
#(
   parameter int NUM_ACC = 10,
   parameter int IDX_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step,
   input  logic [11:0]      key,
   output logic             last,
   output logic             found,
   output logic [IDX_W-1:0] match_idx
);

   logic [IDX_W-1:0] idx;
   logic             hit;

   assign hit  = acc_known(32'(idx)) && (acc_number(32'(idx)) == key);
   assign last = (idx == IDX_W'(NUM_ACC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         found     <= 1'b0;
         match_idx <= '0;
      end else if (start) begin
         idx       <= '0;
         found     <= 1'b0;
         match_idx <= '0;
      end else if (step) begin
         if (hit && !found) begin
            found     <= 1'b1;
            match_idx <= idx;
         end
         if (!last) idx <= idx + 1'b1;
      end
   end

endmodule

// File: rtl/atm_host_responder.sv
// ATM host: accepts one terminal request at a time, looks up accounts by a
// full-length slot scan and answers with a status and the session balance.
module atm_host_responder
   import atm_pkg::*;
#(
   parameter int NUM_ACC        = 10,
   parameter int MAX_FAIL       = 3,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [11:0] req_acc,
   input  logic [3:0]  req_pin,
   input  logic [11:0] req_dest,
   input  logic [10:0] req_amount,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [2:0]  rsp_status,
   output logic [15:0] rsp_balance,
   output logic        session_active
);

   localparam int IDX_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
   localparam int FAIL_W = $clog2(MAX_FAIL + 1);
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e            state;
   req_t              req_q;
   logic [15:0]       bal      [NUM_ACC];
   logic [FAIL_W-1:0] fail_cnt [NUM_ACC];
   logic [IDX_W-1:0]  sess_idx;
   logic [IDLE_W-1:0] idle_cnt;

   logic              accept;
   logic              is_scan_op;
   logic              scan_last;
   logic              scan_found;
   logic [IDX_W-1:0]  match_idx;
   logic [15:0]       src_bal;
   logic [15:0]       dst_bal;
   logic [15:0]       amt_ext;
   logic [16:0]       dst_sum;
   logic [15:0]       sess_bal;

   assign req_ready  = (state == S_IDLE);
   assign accept     = req_valid && req_ready;
   assign is_scan_op = (req_op == OP_LOGIN) || (req_op == OP_TRANSFER);

   acc_scanner #(
      .NUM_ACC (NUM_ACC),
      .IDX_W   (IDX_W)
   ) u_scanner (
      .clk       (clk),
      .rst       (rst),
      .start     (accept),
      .step      (state == S_SEARCH),
      .key       ((req_q.op == OP_LOGIN) ? req_q.acc : req_q.dest),
      .last      (scan_last),
      .found     (scan_found),
      .match_idx (match_idx)
   );

   // NOTE: every always_comb output is assigned on every path, so no latch can form.
   always_comb begin
      src_bal  = bal[sess_idx];
      dst_bal  = bal[match_idx];
      amt_ext  = {5'd0, req_q.amount};
      dst_sum  = {1'b0, dst_bal} + {1'b0, amt_ext};
      sess_bal = session_active ? src_bal : 16'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         req_q          <= '0;
         rsp_valid      <= 1'b0;
         rsp_status     <= ST_OK;
         rsp_balance    <= 16'd0;
         session_active <= 1'b0;
         sess_idx       <= '0;
         idle_cnt       <= '0;
         // NOTE: balances and fail counts are architectural state restored on reset, so this is flops, not RAM.
         for (int i = 0; i < NUM_ACC; i++) begin
            bal[i]      <= INIT_BALANCE;
            fail_cnt[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  req_q    <= '{op: req_op, acc: req_acc, pin: req_pin,
                                dest: req_dest, amount: req_amount};
                  idle_cnt <= '0;
                  state    <= is_scan_op ? S_SEARCH : S_EXEC;
               end else if (session_active) begin
                  // The timeout drops the session silently; an accept in the same cycle wins above.
                  if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                     session_active <= 1'b0;
                     idle_cnt       <= '0;
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end else begin
                  idle_cnt <= '0;
               end
            end

            S_SEARCH: begin
               if (scan_last) state <= S_EXEC;
            end

            S_EXEC: begin
               rsp_valid   <= 1'b1;
               rsp_status  <= ST_OK;
               rsp_balance <= sess_bal;
               state       <= S_RESPOND;
               case (op_e'(req_q.op))
                  OP_LOGIN: begin
                     if (!scan_found) begin
                        rsp_status <= ST_BAD_CRED;
                     end else if (fail_cnt[match_idx] >= FAIL_W'(MAX_FAIL)) begin
                        rsp_status <= ST_LOCKED;
                     end else if (req_q.pin != acc_pin(32'(match_idx))) begin
                        rsp_status <= ST_BAD_CRED;
                        if (fail_cnt[match_idx] != FAIL_W'(MAX_FAIL))
                           fail_cnt[match_idx] <= fail_cnt[match_idx] + 1'b1;
                     end else begin
                        fail_cnt[match_idx] <= '0;
                        session_active      <= 1'b1;
                        sess_idx            <= match_idx;
                        rsp_balance         <= dst_bal;
                     end
                  end

                  OP_LOGOUT: begin
                     session_active <= 1'b0;
                     rsp_balance    <= 16'd0;
                  end

                  OP_BALANCE: begin
                     if (!session_active) rsp_status <= ST_NO_SESSION;
                  end

                  OP_WITHDRAW: begin
                     if (!session_active) begin
                        rsp_status <= ST_NO_SESSION;
                     end else if (amt_ext > src_bal) begin
                        rsp_status <= ST_NO_FUNDS;
                     end else begin
                        bal[sess_idx] <= src_bal - amt_ext;
                        rsp_balance   <= src_bal - amt_ext;
                     end
                  end

                  OP_TRANSFER: begin
                     if (!session_active) begin
                        rsp_status <= ST_NO_SESSION;
                     end else if (!scan_found) begin
                        rsp_status <= ST_BAD_DEST;
                     end else if (amt_ext > src_bal) begin
                        rsp_status <= ST_NO_FUNDS;
                     end else if (match_idx == sess_idx) begin
                        rsp_status <= ST_OK;
                     end else if (dst_sum[16]) begin
                        rsp_status <= ST_OVERFLOW;
                     end else begin
                        bal[sess_idx]  <= src_bal - amt_ext;
                        bal[match_idx] <= dst_sum[15:0];
                        rsp_balance    <= src_bal - amt_ext;
                     end
                  end

                  default: rsp_status <= ST_BAD_OP;
               endcase
            end

            S_RESPOND: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_atm_host_responder.sv
// Directed bench for atm_host_responder: login, funds movement, lockout,
// back-pressure, illegal ops, session timeout and reset during a scan.
module tb_atm_host_responder;

   localparam logic [2:0] OP_LOGIN = 3'd0, OP_LOGOUT = 3'd1, OP_BAL = 3'd2,
                          OP_WD = 3'd3, OP_XFER = 3'd4;
   localparam logic [2:0] S_OK = 3'd0, S_BAD_CRED = 3'd1, S_LOCKED = 3'd2,
                          S_NO_FUNDS = 3'd3, S_NO_SESSION = 3'd4, S_BAD_DEST = 3'd5,
                          S_BAD_OP = 3'd7;
   localparam int TIMEOUT = 1000;
   localparam int LAT_SCAN = 12;
   localparam int LAT_DIRECT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [11:0] req_acc;
   logic [3:0]  req_pin;
   logic [11:0] req_dest;
   logic [10:0] req_amount;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [2:0]  rsp_status;
   logic [15:0] rsp_balance;
   logic        session_active;

   int n_tests = 0;
   int n_fail  = 0;

   int          got_lat;
   logic [2:0]  got_st;
   logic [15:0] got_bal;

   typedef struct {
      logic [2:0]  op;
      logic [11:0] acc;
      logic [3:0]  pin;
      logic [11:0] dest;
      logic [10:0] amt;
      logic [2:0]  st;
      logic [15:0] bal;
      int          lat;
   } vec_t;

   atm_host_responder #(
      .NUM_ACC        (10),
      .MAX_FAIL       (3),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_op         (req_op),
      .req_acc        (req_acc),
      .req_pin        (req_pin),
      .req_dest       (req_dest),
      .req_amount     (req_amount),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_status     (rsp_status),
      .rsp_balance    (rsp_balance),
      .session_active (session_active)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one request from an idle cycle and wait for rsp_valid; latency is
   // counted in cycles with the accept cycle as cycle 0.
   task automatic send_req(input logic [2:0] op, input logic [11:0] acc,
                           input logic [3:0] pin, input logic [11:0] dest,
                           input logic [10:0] amt);
      req_op = op; req_acc = acc; req_pin = pin; req_dest = dest; req_amount = amt;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_op = 3'd7; req_acc = 12'hfff; req_pin = 4'hf; req_dest = 12'hfff; req_amount = 11'h7ff;
      got_lat = 1;
      while (!rsp_valid && got_lat < 200) begin
         @(posedge clk); #1;
         got_lat++;
      end
      if (!rsp_valid) begin
         n_tests++; n_fail++;
         $display("FAIL rsp_timeout: rsp_valid not seen within %0d cycles (op %0d)", got_lat, op);
      end
      got_st  = rsp_status;
      got_bal = rsp_balance;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      pulse_reset();
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
      n_tests++; if (rsp_status !== 3'd0) begin n_fail++; $display("FAIL reset_rsp_status got %0d want 0", rsp_status); end
      n_tests++; if (rsp_balance !== 16'd0) begin n_fail++; $display("FAIL reset_rsp_balance got %0d want 0", rsp_balance); end
      n_tests++; if (session_active !== 1'b0) begin n_fail++; $display("FAIL reset_session got %0b want 0", session_active); end
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
   endtask

   task automatic test_login();
      send_req(OP_LOGIN, 12'd2175, 4'd1, 12'd0, 11'd0);
      finish_rsp();
      n_tests++; if (got_st !== S_OK) begin n_fail++; $display("FAIL login_status got %0d want %0d", got_st, S_OK); end
      n_tests++; if (got_lat !== LAT_SCAN) begin n_fail++; $display("FAIL login_latency got %0d want %0d", got_lat, LAT_SCAN); end
      n_tests++; if (got_bal !== 16'd500) begin n_fail++; $display("FAIL login_balance got %0d want 500", got_bal); end
      n_tests++; if (session_active !== 1'b1) begin n_fail++; $display("FAIL login_session got %0b want 1", session_active); end
   endtask

   task automatic test_withdraw();
      vec_t v[3];
      v[0] = '{OP_WD, 12'd0, 4'd0, 12'd0, 11'd200, S_OK,       16'd300, LAT_DIRECT};
      v[1] = '{OP_WD, 12'd0, 4'd0, 12'd0, 11'd301, S_NO_FUNDS, 16'd300, LAT_DIRECT};
      v[2] = '{OP_WD, 12'd0, 4'd0, 12'd0, 11'd0,   S_OK,       16'd300, LAT_DIRECT};
      for (int i = 0; i < 3; i++) begin
         send_req(v[i].op, v[i].acc, v[i].pin, v[i].dest, v[i].amt);
         finish_rsp();
         n_tests++; if (got_st !== v[i].st) begin n_fail++; $display("FAIL withdraw[%0d]_status got %0d want %0d", i, got_st, v[i].st); end
         n_tests++; if (got_bal !== v[i].bal) begin n_fail++; $display("FAIL withdraw[%0d]_balance got %0d want %0d", i, got_bal, v[i].bal); end
         n_tests++; if (got_lat !== v[i].lat) begin n_fail++; $display("FAIL withdraw[%0d]_latency got %0d want %0d", i, got_lat, v[i].lat); end
      end
   endtask

   task automatic test_transfer();
      vec_t v[6];
      v[0] = '{OP_XFER,  12'd0,    4'd0, 12'd2689, 11'd100, S_OK,       16'd200, LAT_SCAN};
      v[1] = '{OP_XFER,  12'd0,    4'd0, 12'd1234, 11'd10,  S_BAD_DEST, 16'd200, LAT_SCAN};
      v[2] = '{OP_XFER,  12'd0,    4'd0, 12'd2689, 11'd201, S_NO_FUNDS, 16'd200, LAT_SCAN};
      v[3] = '{OP_XFER,  12'd0,    4'd0, 12'd2175, 11'd50,  S_OK,       16'd200, LAT_SCAN};
      v[4] = '{OP_LOGIN, 12'd2689, 4'd9, 12'd0,    11'd0,   S_OK,       16'd600, LAT_SCAN};
      v[5] = '{OP_BAL,   12'd0,    4'd0, 12'd0,    11'd0,   S_OK,       16'd600, LAT_DIRECT};
      for (int i = 0; i < 6; i++) begin
         send_req(v[i].op, v[i].acc, v[i].pin, v[i].dest, v[i].amt);
         finish_rsp();
         n_tests++; if (got_st !== v[i].st) begin n_fail++; $display("FAIL transfer[%0d]_status got %0d want %0d", i, got_st, v[i].st); end
         n_tests++; if (got_bal !== v[i].bal) begin n_fail++; $display("FAIL transfer[%0d]_balance got %0d want %0d", i, got_bal, v[i].bal); end
         n_tests++; if (got_lat !== v[i].lat) begin n_fail++; $display("FAIL transfer[%0d]_latency got %0d want %0d", i, got_lat, v[i].lat); end
      end
   endtask

   // Session on 2689 (balance 600) stays open through the failed logins.
   task automatic test_lockout();
      vec_t v[5];
      v[0] = '{OP_LOGIN, 12'd2429, 4'd5, 12'd0, 11'd0, S_BAD_CRED, 16'd600, LAT_SCAN};
      v[1] = '{OP_LOGIN, 12'd2429, 4'd5, 12'd0, 11'd0, S_BAD_CRED, 16'd600, LAT_SCAN};
      v[2] = '{OP_LOGIN, 12'd2429, 4'd5, 12'd0, 11'd0, S_BAD_CRED, 16'd600, LAT_SCAN};
      v[3] = '{OP_LOGIN, 12'd2429, 4'd2, 12'd0, 11'd0, S_LOCKED,   16'd600, LAT_SCAN};
      v[4] = '{OP_LOGIN, 12'd1234, 4'd2, 12'd0, 11'd0, S_BAD_CRED, 16'd600, LAT_SCAN};
      for (int i = 0; i < 5; i++) begin
         send_req(v[i].op, v[i].acc, v[i].pin, v[i].dest, v[i].amt);
         finish_rsp();
         n_tests++; if (got_st !== v[i].st) begin n_fail++; $display("FAIL lockout[%0d]_status got %0d want %0d", i, got_st, v[i].st); end
         n_tests++; if (got_bal !== v[i].bal) begin n_fail++; $display("FAIL lockout[%0d]_balance got %0d want %0d", i, got_bal, v[i].bal); end
      end
      pulse_reset();
      send_req(OP_LOGIN, 12'd2689, 4'd9, 12'd0, 11'd0);
      finish_rsp();
      n_tests++; if (got_bal !== 16'd500) begin n_fail++; $display("FAIL lockout_reset_balance got %0d want 500", got_bal); end
      send_req(OP_LOGIN, 12'd2429, 4'd2, 12'd0, 11'd0);
      finish_rsp();
      n_tests++; if (got_st !== S_OK) begin n_fail++; $display("FAIL lockout_unlock_status got %0d want %0d", got_st, S_OK); end
      n_tests++; if (got_bal !== 16'd500) begin n_fail++; $display("FAIL lockout_unlock_balance got %0d want 500", got_bal); end
   endtask

   task automatic test_backpressure();
      int unstable = 0;
      int ready_seen = 0;
      rsp_ready = 1'b0;
      send_req(OP_BAL, 12'd0, 4'd0, 12'd0, 11'd0);
      for (int i = 0; i < 20; i++) begin
         req_valid = 1'b1; req_op = OP_LOGOUT;
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_status !== got_st || rsp_balance !== got_bal) unstable++;
         if (req_ready !== 1'b0) ready_seen++;
      end
      req_valid = 1'b0;
      finish_rsp();
      n_tests++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable got %0d changed cycles want 0", unstable); end
      n_tests++; if (ready_seen !== 0) begin n_fail++; $display("FAIL bp_req_ready got %0d ready cycles want 0", ready_seen); end
      n_tests++; if (got_st !== S_OK) begin n_fail++; $display("FAIL bp_status got %0d want %0d", got_st, S_OK); end
      n_tests++; if (got_bal !== 16'd500) begin n_fail++; $display("FAIL bp_balance got %0d want 500", got_bal); end
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %0b want 0", rsp_valid); end
      n_tests++; if (session_active !== 1'b1) begin n_fail++; $display("FAIL bp_session got %0b want 1", session_active); end
   endtask

   task automatic test_bad_ops();
      vec_t v[5];
      v[0] = '{3'd6,      12'd0, 4'd0, 12'd2689, 11'd5,  S_BAD_OP,     16'd500, LAT_DIRECT};
      v[1] = '{OP_LOGOUT, 12'd0, 4'd0, 12'd0,    11'd0,  S_OK,         16'd0,   LAT_DIRECT};
      v[2] = '{OP_BAL,    12'd0, 4'd0, 12'd0,    11'd0,  S_NO_SESSION, 16'd0,   LAT_DIRECT};
      v[3] = '{OP_WD,     12'd0, 4'd0, 12'd0,    11'd10, S_NO_SESSION, 16'd0,   LAT_DIRECT};
      v[4] = '{OP_XFER,   12'd0, 4'd0, 12'd2689, 11'd10, S_NO_SESSION, 16'd0,   LAT_SCAN};
      for (int i = 0; i < 5; i++) begin
         send_req(v[i].op, v[i].acc, v[i].pin, v[i].dest, v[i].amt);
         finish_rsp();
         n_tests++; if (got_st !== v[i].st) begin n_fail++; $display("FAIL badop[%0d]_status got %0d want %0d", i, got_st, v[i].st); end
         n_tests++; if (got_bal !== v[i].bal) begin n_fail++; $display("FAIL badop[%0d]_balance got %0d want %0d", i, got_bal, v[i].bal); end
         n_tests++; if (got_lat !== v[i].lat) begin n_fail++; $display("FAIL badop[%0d]_latency got %0d want %0d", i, got_lat, v[i].lat); end
      end
      n_tests++; if (session_active !== 1'b0) begin n_fail++; $display("FAIL badop_session got %0b want 0", session_active); end
   endtask

   task automatic test_timeout();
      send_req(OP_LOGIN, 12'd2175, 4'd1, 12'd0, 11'd0);
      finish_rsp();
      n_tests++; if (got_st !== S_OK) begin n_fail++; $display("FAIL timeout_login got %0d want %0d", got_st, S_OK); end
      repeat (TIMEOUT - 10) @(posedge clk);
      #1;
      n_tests++; if (session_active !== 1'b1) begin n_fail++; $display("FAIL timeout_early got %0b want 1", session_active); end
      repeat (20) @(posedge clk);
      #1;
      n_tests++; if (session_active !== 1'b0) begin n_fail++; $display("FAIL timeout_expired got %0b want 0", session_active); end
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_no_rsp got %0b want 0", rsp_valid); end
      send_req(OP_BAL, 12'd0, 4'd0, 12'd0, 11'd0);
      finish_rsp();
      n_tests++; if (got_st !== S_NO_SESSION) begin n_fail++; $display("FAIL timeout_balance got %0d want %0d", got_st, S_NO_SESSION); end
   endtask

   task automatic test_reset_mid_scan();
      int seen = 0;
      req_op = OP_LOGIN; req_acc = 12'd2175; req_pin = 4'd1; req_dest = 12'd0; req_amount = 11'd0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midscan_rsp_valid got %0b want 0", rsp_valid); end
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midscan_req_ready got %0b want 1", req_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
      end
      n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL midscan_no_rsp got %0d valid cycles want 0", seen); end
      n_tests++; if (session_active !== 1'b0) begin n_fail++; $display("FAIL midscan_session got %0b want 0", session_active); end
      send_req(OP_BAL, 12'd0, 4'd0, 12'd0, 11'd0);
      finish_rsp();
      n_tests++; if (got_st !== S_NO_SESSION) begin n_fail++; $display("FAIL midscan_balance got %0d want %0d", got_st, S_NO_SESSION); end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_op = '0; req_acc = '0; req_pin = '0; req_dest = '0; req_amount = '0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_login();
      test_withdraw();
      test_transfer();
      test_lockout();
      test_backpressure();
      test_bad_ops();
      test_timeout();
      test_reset_mid_scan();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
